// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//
// Registers the EX/MEM payload, runs the data-memory request/response
// handshake for loads and stores, aligns and extends load data, and hands
// result/destination/wb_ctrl to writeback. While an access is in flight
// the stage raises stall_o so EX and earlier stages hold.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pc_i .. exc_tag_i   EX/MEM payload from the execute stage
//   flush_i             kill the instruction currently in this stage
//   data_*              data-memory request (req/wr/size/addr/wdata),
//                       handshake (addr_ok/data_ok) and read data
//   stall_o             hold upstream stages
//   pc_o .. exc_tag_o   registered payload / result to writeback
//   fwd_data_o          copy of result_o for the forwarding unit
module mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [31:0]      inst_i,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic [WIDTH-1:0] rd2_i,
    input  logic [9:0]       wb_ctrl_i,
    input  logic [16:0]      mem_ctrl_i,
    input  logic [4:0]       dest_i,
    input  logic [6:0]       exc_tag_i,
    input  logic             flush_i,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [WIDTH-1:0] data_addr,
    output logic [WIDTH-1:0] data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [WIDTH-1:0] data_rdata,
    output logic             stall_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [31:0]      inst_o,
    output logic [9:0]       wb_ctrl_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       dest_o,
    output logic [6:0]       exc_tag_o,
    output logic [WIDTH-1:0] fwd_data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Stage register
    logic [WIDTH-1:0] pc_q, alu_q, rd2_q, rdata_q;
    logic [31:0]      inst_q;
    logic [9:0]       wb_q;
    logic [16:0]      mc_q;
    logic [4:0]       dest_q;
    logic [6:0]       tag_q;
    logic             valid_q;
    logic             kill_q;

    // Decoded memory controls
    logic [1:0] byte_sel;
    logic       mem_read, mem_write, load_unsigned;
    logic [1:0] size;

    assign byte_sel      = mc_q[16:15];
    assign mem_read      = mc_q[14];
    assign mem_write     = mc_q[13];
    assign size          = mc_q[12:11];
    assign load_unsigned = mc_q[10];

    // Reserved control bits travel through the register but drive nothing here.
    logic unused_reserved;
    assign unused_reserved = ^mc_q[9:0];

    logic pending, accept;

    assign pending = valid_q & (mem_read | mem_write) & (tag_q == 7'd0) & ~kill_q;
    assign accept  = (state == S_IDLE) & pending & data_addr_ok;

    // A killed access still has to be drained, so WAIT stalls regardless of
    // pending; DONE never stalls so the next instruction loads on that edge.
    assign stall_o = ((state == S_IDLE) & pending) | (state == S_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        // NOTE: rdata_q is reset along with the payload so result_o is
        // deterministic out of reset; it is a single register, not a memory.
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            wb_q    <= '0;
            mc_q    <= '0;
            dest_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && data_data_ok) begin
                rdata_q <= data_rdata;
            end
            if (!stall_o) begin
                pc_q    <= pc_i;
                inst_q  <= inst_i;
                alu_q   <= alu_out_i;
                rd2_q   <= rd2_i;
                wb_q    <= wb_ctrl_i;
                mc_q    <= mem_ctrl_i;
                dest_q  <= dest_i;
                tag_q   <= exc_tag_i;
                valid_q <= 1'b1;
                kill_q  <= 1'b0;
            end else if (flush_i) begin
                // Once the memory has accepted the request the access must
                // finish; only the writeback is suppressed.
                if (accept || state == S_WAIT) begin
                    kill_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        data_req  = 1'b0;
        unique case (state)
            S_IDLE: begin
                data_req = pending;
                if (accept) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (data_data_ok) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load alignment and extension
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        byte_v = 8'h00;
        unique case (byte_sel)
            2'd0: byte_v = rdata_q[7:0];
            2'd1: byte_v = rdata_q[15:8];
            2'd2: byte_v = rdata_q[23:16];
            2'd3: byte_v = rdata_q[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = byte_sel[1] ? rdata_q[31:16] : rdata_q[15:0];

        load_data = rdata_q;
        case (size)
            2'd0:    load_data = {{24{~load_unsigned & byte_v[7]}}, byte_v};
            2'd1:    load_data = {{16{~load_unsigned & half_v[15]}}, half_v};
            default: load_data = rdata_q;
        endcase
    end

    // Store data replicated across lanes so byte enables alone pick the lane.
    always_comb begin
        data_wdata = rd2_q;
        case (size)
            2'd0:    data_wdata = {4{rd2_q[7:0]}};
            2'd1:    data_wdata = {2{rd2_q[15:0]}};
            default: data_wdata = rd2_q;
        endcase
    end

    assign data_wr   = mem_write;
    assign data_size = size;
    assign data_addr = alu_q;

    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign dest_o     = dest_q;
    assign exc_tag_o  = tag_q;
    assign wb_ctrl_o  = (stall_o | ~valid_q | kill_q) ? 10'd0 : wb_q;
    assign result_o   = mem_read ? load_data : alu_q;
    assign fwd_data_o = result_o;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Inputs change 1 ns after a rising edge,
// outputs are checked at the same point, well away from the next edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i, inst_i, alu_out_i, rd2_i;
    logic [9:0]  wb_ctrl_i;
    logic [16:0] mem_ctrl_i;
    logic [4:0]  dest_i;
    logic [6:0]  exc_tag_i;
    logic        flush_i;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_o;
    logic [31:0] pc_o, inst_o, result_o, fwd_data_o;
    logic [9:0]  wb_ctrl_o;
    logic [4:0]  dest_o;
    logic [6:0]  exc_tag_o;

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] WB = 10'h2A5;

    always #5 clk = ~clk;

    mem_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .pc_i(pc_i), .inst_i(inst_i), .alu_out_i(alu_out_i), .rd2_i(rd2_i),
        .wb_ctrl_i(wb_ctrl_i), .mem_ctrl_i(mem_ctrl_i), .dest_i(dest_i),
        .exc_tag_i(exc_tag_i), .flush_i(flush_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .stall_o(stall_o), .pc_o(pc_o), .inst_o(inst_o), .wb_ctrl_o(wb_ctrl_o),
        .result_o(result_o), .dest_o(dest_o), .exc_tag_o(exc_tag_o),
        .fwd_data_o(fwd_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mc(input logic [1:0] sel, input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic uns);
        return {sel, rd, wr, sz, uns, 10'h155};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [16:0] mctl, input logic [6:0] tag);
        pc_i       = pc;
        inst_i     = pc ^ 32'hA5A5_0000;
        alu_out_i  = alu;
        rd2_i      = rd2;
        wb_ctrl_i  = WB;
        mem_ctrl_i = mctl;
        dest_i     = pc[6:2];
        exc_tag_i  = tag;
    endtask

    initial begin
        // Reset with junk on the inputs
        reset = 1'b1; flush_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;
        drive(32'h0000_0040, 32'h0000_0444, 32'h1234_5678, mc(2'd1, 1'b1, 1'b0, 2'd2, 1'b0), 7'h00);
        tick(); tick();
        check("rst_req",    {31'd0, data_req}, 32'd0);
        check("rst_stall",  {31'd0, stall_o},  32'd0);
        check("rst_pc",     pc_o,              32'd0);
        check("rst_inst",   inst_o,            32'd0);
        check("rst_wb",     {22'd0, wb_ctrl_o}, 32'd0);
        check("rst_result", result_o,          32'd0);
        check("rst_fwd",    fwd_data_o,        32'd0);
        check("rst_dest",   {27'd0, dest_o},   32'd0);
        check("rst_tag",    {25'd0, exc_tag_o}, 32'd0);
        check("rst_addr",   data_addr,         32'd0);
        check("rst_wdata",  data_wdata,        32'd0);

        // ALU op: one cycle, no request
        reset = 1'b0;
        drive(32'h0000_0100, 32'h0000_1234, 32'h0, 17'd0, 7'h00);
        tick();
        check("alu_result", result_o,          32'h0000_1234);
        check("alu_fwd",    fwd_data_o,        32'h0000_1234);
        check("alu_stall",  {31'd0, stall_o},  32'd0);
        check("alu_req",    {31'd0, data_req}, 32'd0);
        check("alu_wb",     {22'd0, wb_ctrl_o}, {22'd0, WB});
        check("alu_pc",     pc_o,              32'h0000_0100);

        // LB byte_sel=2, addr_ok immediately, data_ok next cycle
        drive(32'h0000_0104, 32'h0000_0202, 32'h0, mc(2'd2, 1'b1, 1'b0, 2'd0, 1'b0), 7'h00);
        tick();
        check("lb_req",     {31'd0, data_req}, 32'd1);
        check("lb_wr",      {31'd0, data_wr},  32'd0);
        check("lb_stall0",  {31'd0, stall_o},  32'd1);
        check("lb_wb0",     {22'd0, wb_ctrl_o}, 32'd0);
        check("lb_addr",    data_addr,         32'h0000_0202);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("lb_req_wait", {31'd0, data_req}, 32'd0);
        check("lb_stall1",   {31'd0, stall_o},  32'd1);
        data_data_ok = 1'b1; data_rdata = 32'h0080_FF00;
        // Next instruction (LBU, same address) waits upstream
        drive(32'h0000_0108, 32'h0000_0202, 32'h0, mc(2'd2, 1'b1, 1'b0, 2'd0, 1'b1), 7'h00);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        check("lb_done_stall", {31'd0, stall_o},  32'd0);
        check("lb_result",     result_o,          32'hFFFF_FF80);
        check("lb_wb",         {22'd0, wb_ctrl_o}, {22'd0, WB});
        check("lb_pc_held",    pc_o,              32'h0000_0104);

        // LBU
        tick();
        check("lbu_pc",  pc_o, 32'h0000_0108);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0080_FF00;
        // Next: LH byte_sel=2 (upper half), signed
        drive(32'h0000_010C, 32'h0000_0302, 32'h0, mc(2'd2, 1'b1, 1'b0, 2'd1, 1'b0), 7'h00);
        tick();
        data_data_ok = 1'b0;
        check("lbu_result", result_o, 32'h0000_0080);

        // LH upper halfword
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8001_1234;
        // Next: SH rd2=0xAAAABEEF to 0x102
        drive(32'h0000_0110, 32'h0000_0102, 32'hAAAA_BEEF, mc(2'd2, 1'b0, 1'b1, 2'd1, 1'b0), 7'h00);
        tick();
        data_data_ok = 1'b0;
        check("lh_result", result_o, 32'hFFFF_8001);

        // SH with addr_ok delayed 3 cycles
        tick();
        check("sh_wr",    {31'd0, data_wr},   32'd1);
        check("sh_size",  {30'd0, data_size}, 32'd1);
        check("sh_wdata", data_wdata,         32'hBEEF_BEEF);
        check("sh_addr",  data_addr,          32'h0000_0102);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sh_req_hold%0d", i),   {31'd0, data_req}, 32'd1);
            check($sformatf("sh_stall_hold%0d", i), {31'd0, stall_o},  32'd1);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("sh_req_acc", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1;
        // Next: load with exception tag
        drive(32'h0000_0114, 32'h0000_0400, 32'h0, mc(2'd0, 1'b1, 1'b0, 2'd2, 1'b0), 7'h01);
        tick();
        data_data_ok = 1'b0;
        check("sh_done_stall", {31'd0, stall_o},  32'd0);
        check("sh_done_wb",    {22'd0, wb_ctrl_o}, {22'd0, WB});

        // Exception-tagged load: no access
        tick();
        check("exc_req",   {31'd0, data_req},  32'd0);
        check("exc_stall", {31'd0, stall_o},   32'd0);
        check("exc_tag",   {25'd0, exc_tag_o}, 32'h01);

        // SB, flushed in IDLE before acceptance
        drive(32'h0000_0118, 32'h0000_0503, 32'h0000_005A, mc(2'd3, 1'b0, 1'b1, 2'd0, 1'b0), 7'h00);
        tick();
        check("sb_wdata", data_wdata,         32'h5A5A_5A5A);
        check("sb_req",   {31'd0, data_req},  32'd1);
        flush_i = 1'b1;
        drive(32'h0000_011C, 32'h0000_0600, 32'h0, mc(2'd0, 1'b1, 1'b0, 2'd2, 1'b0), 7'h00);
        tick();
        flush_i = 1'b0;
        check("fl_idle_req",   {31'd0, data_req},  32'd0);
        check("fl_idle_stall", {31'd0, stall_o},   32'd0);
        check("fl_idle_wb",    {22'd0, wb_ctrl_o}, 32'd0);

        // LW flushed in WAIT, data_ok two cycles later
        tick();
        check("fw_pc", pc_o, 32'h0000_011C);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fw_stall0", {31'd0, stall_o},   32'd1);
        check("fw_wb0",    {22'd0, wb_ctrl_o}, 32'd0);
        tick();
        check("fw_stall1", {31'd0, stall_o},   32'd1);
        check("fw_wb1",    {22'd0, wb_ctrl_o}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h5555_6666;
        drive(32'h0000_0120, 32'h0000_0777, 32'h0, 17'd0, 7'h00);
        tick();
        data_data_ok = 1'b0;
        check("fw_done_stall", {31'd0, stall_o},   32'd0);
        check("fw_done_wb",    {22'd0, wb_ctrl_o}, 32'd0);
        tick();
        check("fw_next_wb",     {22'd0, wb_ctrl_o}, {22'd0, WB});
        check("fw_next_result", result_o,           32'h0000_0777);

        // Reset while in WAIT, then a stale data_ok
        drive(32'h0000_0124, 32'h0000_0800, 32'h0, mc(2'd0, 1'b1, 1'b0, 2'd2, 1'b0), 7'h00);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; reset = 1'b1;
        tick();
        check("rw_req",   {31'd0, data_req}, 32'd0);
        check("rw_stall", {31'd0, stall_o},  32'd0);
        reset = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        tick();
        check("rw_stale_req0", {31'd0, data_req}, 32'd1);
        tick();
        check("rw_stale_req1", {31'd0, data_req}, 32'd1);
        check("rw_stale_wb",   {22'd0, wb_ctrl_o}, 32'd0);
        data_data_ok = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
        drive(32'h0000_0128, 32'h0, 32'h0, 17'd0, 7'h00);
        tick();
        data_data_ok = 1'b0;
        check("rw_result", result_o,           32'h1122_3344);
        check("rw_wb",     {22'd0, wb_ctrl_o}, {22'd0, WB});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
